// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with a three-state control FSM.
//
// Walks the PC through instruction memory, latches each word into IR_out,
// handles absolute and PC-relative branches (which flush IR_valid), honours
// stalls, and stops fetching when it reads HALT_CODE.
//
// Ports
//   Clk            in   1   rising-edge clock
//   Reset          in   1   asynchronous active-high reset
//   Start          in   1   begin/restart fetching from START_ADDR (IDLE/HALT only)
//   Stall          in   1   hold PC, IR_out, IR_valid and FetchCount
//   BranchTaken    in   1   redirect PC; wins over Stall
//   BranchAbs      in   1   1: target = TargetAddr, 0: target = PC + Offset
//   TargetAddr     in  12   absolute branch target
//   Offset         in   8   signed relative branch offset
//   Instruction_in in   9   memory word at PC_out
//   PC_out         out 12   registered program counter
//   IR_out         out  9   registered instruction
//   IR_valid       out  1   IR_out holds a fresh, non-flushed instruction
//   Halted         out  1   registered, high exactly while in HALT
//   FetchCount     out 16   saturating count of valid fetches
module fetch_unit #(
    parameter logic [11:0] START_ADDR = 12'h000,
    parameter logic [8:0]  HALT_CODE  = 9'h1FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic        BranchAbs,
    input  logic [11:0] TargetAddr,
    input  logic [7:0]  Offset,
    input  logic [8:0]  Instruction_in,
    output logic [11:0] PC_out,
    output logic [8:0]  IR_out,
    output logic        IR_valid,
    output logic        Halted,
    output logic [15:0] FetchCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [8:0]  ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        halted_q;
    logic [15:0] count_q, count_d;

    logic [11:0] branch_target;
    logic [15:0] count_inc;

    // Relative target wraps modulo 4096 through natural 12-bit truncation.
    assign branch_target = BranchAbs ? TargetAddr : (pc_q + {{4{Offset[7]}}, Offset});
    assign count_inc     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    valid_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The halt word is presented to the decoder for exactly one
                // valid cycle; the following edge commits to HALT regardless
                // of stall/branch, since nothing past a halt may execute.
                if (valid_q && ir_q == HALT_CODE) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (BranchTaken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    ir_d    = Instruction_in;
                    valid_d = 1'b1;
                    count_d = count_inc;
                    // PC parks on the halt address.
                    if (Instruction_in != HALT_CODE) begin
                        pc_d = pc_q + 12'd1;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (Start) begin
                    pc_d    = START_ADDR;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= START_ADDR;
            ir_q     <= 9'h000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= (state_d == HALT);
            count_q  <= count_d;
        end
    end

    assign PC_out     = pc_q;
    assign IR_out     = ir_q;
    assign IR_valid   = valid_q;
    assign Halted     = halted_q;
    assign FetchCount = count_q;

endmodule
